// File: rtl/cic_comp_fir.sv
// Time-multiplexed CIC-compensation FIR decimator: circular sample buffer,
// one MAC per cycle over N_TAPS, then round-half-up, saturate and emit.
module cic_comp_fir #(
  parameter int DATA_WIDTH       = 12,
  parameter int COEF_WIDTH       = 16,
  parameter int N_TAPS           = 16,
  parameter int ACC_WIDTH        = 40,
  parameter int DECIMATION_RATIO = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic signed [DATA_WIDTH-1:0]  data_in,
  input  logic                          data_clk,
  input  logic                          coef_we,
  input  logic [$clog2(N_TAPS)-1:0]     coef_addr,
  input  logic signed [COEF_WIDTH-1:0]  coef_data,
  output logic signed [DATA_WIDTH-1:0]  data_out,
  output logic                          out_valid,
  output logic                          busy,
  output logic                          overrun
);

  localparam int AW        = $clog2(N_TAPS);
  localparam int PHW       = (DECIMATION_RATIO > 1) ? $clog2(DECIMATION_RATIO) : 1;
  localparam int PROD_W    = DATA_WIDTH + COEF_WIDTH;
  localparam int COEF_FRAC = COEF_WIDTH - 2;

  localparam logic [AW-1:0]  LAST_TAP   = AW'(N_TAPS - 1);
  localparam logic [PHW-1:0] LAST_PHASE = PHW'(DECIMATION_RATIO - 1);

  localparam logic signed [COEF_WIDTH-1:0] COEF_ONE = {2'b01, {COEF_FRAC{1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0]  RND      = (ACC_WIDTH)'(1) <<< (COEF_FRAC - 1);
  localparam logic signed [ACC_WIDTH-1:0]  OUT_MAX  =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0]  OUT_MIN  =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic                         data_clk_q;
  logic signed [DATA_WIDTH-1:0] buf_q  [N_TAPS];
  logic signed [COEF_WIDTH-1:0] coef_q [N_TAPS];
  logic [AW-1:0]                wr_ptr_q;
  logic [AW-1:0]                rd_ptr_q;
  logic [AW-1:0]                k_q;
  logic [PHW-1:0]               phase_q;
  logic signed [ACC_WIDTH-1:0]  acc_q;
  logic signed [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                         out_valid_q;
  logic                         overrun_q;

  logic                         capture;
  logic                         accept;
  logic signed [PROD_W-1:0]     prod;
  logic signed [ACC_WIDTH-1:0]  mac_sum;
  logic signed [ACC_WIDTH-1:0]  rounded;
  logic signed [ACC_WIDTH-1:0]  scaled;

  assign capture = data_clk && !data_clk_q;
  assign accept  = capture && (state_q == S_IDLE);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept && (phase_q == LAST_PHASE)) state_d = S_MAC;
      S_MAC:   if (k_q == LAST_TAP) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    prod    = PROD_W'(coef_q[k_q]) * PROD_W'(buf_q[rd_ptr_q]);
    mac_sum = acc_q + ACC_WIDTH'(prod);
    rounded = acc_q + RND;
    scaled  = rounded >>> COEF_FRAC;
    if (scaled > OUT_MAX) begin
      data_out_d = OUT_MAX[DATA_WIDTH-1:0];
    end else if (scaled < OUT_MIN) begin
      data_out_d = OUT_MIN[DATA_WIDTH-1:0];
    end else begin
      data_out_d = scaled[DATA_WIDTH-1:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_clk_q  <= 1'b1;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      k_q         <= '0;
      phase_q     <= '0;
      acc_q       <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      // NOTE: the delay line and coefficient bank are reset explicitly because the
      // filter must start from a zero history and an identity response.
      for (int i = 0; i < N_TAPS; i++) begin
        buf_q[i]  <= '0;
        coef_q[i] <= (i == 0) ? COEF_ONE : '0;
      end
    end else begin
      data_clk_q  <= data_clk;
      out_valid_q <= 1'b0;

      if (capture && (state_q != S_IDLE)) begin
        overrun_q <= 1'b1;
      end

      if (accept) begin
        buf_q[wr_ptr_q] <= data_in;
        wr_ptr_q        <= (wr_ptr_q == LAST_TAP) ? '0 : wr_ptr_q + AW'(1);
        if (phase_q == LAST_PHASE) begin
          phase_q  <= '0;
          acc_q    <= '0;
          k_q      <= '0;
          rd_ptr_q <= wr_ptr_q;
        end else begin
          phase_q <= phase_q + PHW'(1);
        end
      end

      // Walk backwards from the newest sample while k walks forward.
      if (state_q == S_MAC) begin
        acc_q    <= mac_sum;
        k_q      <= k_q + AW'(1);
        rd_ptr_q <= (rd_ptr_q == '0) ? LAST_TAP : rd_ptr_q - AW'(1);
      end

      if (state_q == S_DONE) begin
        data_out_q  <= data_out_d;
        out_valid_q <= 1'b1;
      end

      if (coef_we && (32'(coef_addr) < N_TAPS)) begin
        coef_q[coef_addr] <= coef_data;
      end
    end
  end

  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != S_IDLE);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_cic_comp_fir.sv
// Directed bench for cic_comp_fir: stimulus pushes expected outputs and due
// cycles into a scoreboard; a negedge monitor pops and compares on out_valid.
module tb_cic_comp_fir;

  localparam int DW  = 12;
  localparam int CW  = 16;
  localparam int NT  = 16;
  localparam int AW  = 4;
  localparam int LAT = NT + 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic signed [DW-1:0] data_in = '0;
  logic                 data_clk = 1'b0;
  logic                 coef_we = 1'b0;
  logic [AW-1:0]        coef_addr = '0;
  logic signed [CW-1:0] coef_data = '0;
  logic signed [DW-1:0] data_out;
  logic                 out_valid;
  logic                 busy;
  logic                 overrun;

  cic_comp_fir #(
    .DATA_WIDTH(DW), .COEF_WIDTH(CW), .N_TAPS(NT), .ACC_WIDTH(40), .DECIMATION_RATIO(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_clk(data_clk),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .data_out(data_out), .out_valid(out_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int val;
    int due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_out_valid: data_out=%0d at cycle %0d, expected no output",
                 data_out, cyc);
      end else begin
        mon_e = sb.pop_front();
        check("out_value", int'(data_out), mon_e.val);
        check("out_latency", cyc, mon_e.due);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raises data_clk just after an edge; the capture is registered on the next edge.
  task automatic send(input int v, input bit out_exp, input int exp_v);
    exp_t e;
    data_in  = DW'(v);
    data_clk = 1'b1;
    @(posedge clk);
    #1;
    data_clk = 1'b0;
    if (out_exp) begin
      e.val = exp_v;
      e.due = cyc + LAT;
      sb.push_back(e);
    end
  endtask

  task automatic feed(input int v, input bit out_exp, input int exp_v);
    send(v, out_exp, exp_v);
    idle(NT + 3);
  endtask

  task automatic wr_coef(input int a, input int c);
    coef_we   = 1'b1;
    coef_addr = AW'(a);
    coef_data = CW'(c);
    @(posedge clk);
    #1;
    coef_we = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(2);
  endtask

  int hist[$];

  initial begin
    // Reset state
    idle(3);
    check("rst_data_out", int'(data_out), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overrun", int'(overrun), 0);
    rst_n = 1'b1;
    idle(2);

    // Identity filter from reset defaults; busy window spans N_TAPS+1 cycles
    feed(100, 1'b0, 0);
    send(200, 1'b1, 200);
    check("busy_after_capture", int'(busy), 1);
    idle(NT);
    check("busy_in_done", int'(busy), 1);
    idle(1);
    check("busy_after_done", int'(busy), 0);
    check("valid_at_latency", int'(out_valid), 1);
    idle(3);
    feed(300, 1'b0, 0);
    feed(400, 1'b1, 400);

    // Impulse response with three 0.5 taps; 40 samples wrap the delay line twice
    do_reset();
    for (int t = 0; t < 3; t++) wr_coef(t, 8192);
    for (int i = 0; i < 40; i++) begin
      int v;
      int e;
      v = (i == 1 || i == 21) ? 1000 : 0;
      e = (i == 1 || i == 3 || i == 21 || i == 23) ? 500 : 0;
      feed(v, (i % 2) == 1, e);
    end

    // Saturation, then an exact full-scale negative without clamping
    do_reset();
    wr_coef(0, 32767);
    feed(0, 1'b0, 0);
    feed(2047, 1'b1, 2047);
    feed(0, 1'b0, 0);
    feed(-2048, 1'b1, -2048);
    wr_coef(0, 16384);
    feed(0, 1'b0, 0);
    feed(-2048, 1'b1, -2048);

    // Rounding half toward +inf with a 0.5 coefficient
    wr_coef(0, 8192);
    feed(0, 1'b0, 0);
    feed(3, 1'b1, 2);
    feed(0, 1'b0, 0);
    feed(-3, 1'b1, -1);
    feed(0, 1'b0, 0);
    feed(1, 1'b1, 1);
    feed(0, 1'b0, 0);
    feed(-1, 1'b1, 0);

    // Overrun: strobes every 10 cycles; every third strobe lands in a busy window
    do_reset();
    wr_coef(1, 16384);
    wr_coef(2, 16384);
    idle(2);
    hist.delete();
    for (int i = 0; i < 9; i++) begin
      int  v;
      int  e;
      int  n;
      bit  taken;
      bit  comp;
      v     = 10 * (i + 1);
      taken = (i % 3) != 2;
      comp  = (i % 3) == 1;
      if (taken) hist.push_back(v);
      n = hist.size();
      e = 0;
      for (int j = 0; j < 3; j++) begin
        if (n - 1 - j >= 0) e += hist[n-1-j];
      end
      send(v, comp, e);
      if (i == 1) check("overrun_clear", int'(overrun), 0);
      if (i == 2) check("overrun_set", int'(overrun), 1);
      idle(9);
    end
    idle(NT + 3);
    check("overrun_sticky", int'(overrun), 1);

    // Reset mid-MAC aborts the result; a strobe held high across release is ignored
    do_reset();
    check("overrun_cleared_by_reset", int'(overrun), 0);
    feed(5, 1'b0, 0);
    feed(77, 1'b1, 77);
    send(11, 1'b0, 0);
    idle(3);
    send(22, 1'b0, 0);
    idle(5);
    check("busy_mid_mac", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("abort_data_out", int'(data_out), 0);
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_overrun", int'(overrun), 0);
    data_in  = 12'sd33;
    data_clk = 1'b1;
    idle(3);
    rst_n = 1'b1;
    idle(NT + 3);
    check("no_capture_on_held_strobe", int'(busy), 0);
    data_clk = 1'b0;
    idle(2);
    feed(300, 1'b0, 0);
    feed(-400, 1'b1, -400);

    idle(NT + 5);
    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cic_comp_fir.md
# cic_comp_fir

Time-multiplexed CIC-compensation FIR decimator that sits directly downstream of the CIC decimator in the receive chain. It consumes the CIC's decimated sample stream (`data_in` qualified by the `data_clk` strobe) and buffers the samples in a circular delay line. Each output is computed with a single multiply-accumulate over N_TAPS cycles, then rounded, saturated and emitted with a one-cycle valid. Coefficients are register-based, run-time writable, and reset to an identity (pass-through) filter.

## Interface
- DATA_WIDTH, 12: input/output sample width, signed.
- COEF_WIDTH, 16: coefficient width, signed, Q2.(COEF_WIDTH-2); COEF_FRAC = COEF_WIDTH-2.
- N_TAPS, 16: number of taps, ≥2.
- ACC_WIDTH, 40: accumulator width; must be ≥ DATA_WIDTH+COEF_WIDTH+$clog2(N_TAPS).
- DECIMATION_RATIO, 2: an output is computed for every DECIMATION_RATIO-th captured sample, ≥1.
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- data_in  in  DATA_WIDTH  signed CIC output; stable while data_clk is high.
- data_clk  in  1  CIC sample strobe; a rising edge (0→1 between consecutive clk samples) marks a new sample.
- coef_we  in  1  coefficient write enable.
- coef_addr  in  $clog2(N_TAPS)  tap index; writes to indices ≥ N_TAPS are ignored.
- coef_data  in  COEF_WIDTH  coefficient value.
- data_out  out  DATA_WIDTH  signed filtered sample, held until next update.
- out_valid  out  1  one-cycle pulse when data_out updates.
- busy  out  1  high while the MAC or output stage is active.
- overrun  out  1  sticky flag: a sample arrived while busy; cleared only by reset.

## Operation
- Edge detect: data_clk_q registers data_clk. Capture when data_clk=1 and data_clk_q=0. data_clk_q resets to 1, so a strobe already high at reset release is not captured.
- Capture in IDLE:
  - Write data_in to buffer[wr_ptr]. wr_ptr wraps modulo N_TAPS.
  - If phase == DECIMATION_RATIO-1: phase←0, acc←0, k←0, state←MAC.
  - Otherwise: phase←phase+1 and stay in IDLE.
- Capture while busy (MAC/DONE): sample is dropped. Buffer, wr_ptr and phase are unchanged; overrun←1.
- MAC (N_TAPS cycles, k=0..N_TAPS-1): acc += coef[k] × x[n-k], where x[n] is the newest sample. The product is full precision (DATA_WIDTH+COEF_WIDTH) and sign-extended to ACC_WIDTH; no wrap is possible. After k=N_TAPS-1, state←DONE.
- DONE (1 cycle):
  - data_out ← saturate(( acc + 2^(COEF_FRAC-1) ) >>> COEF_FRAC). This rounds half toward +∞ and clamps to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - out_valid←1; state←IDLE.
- States: IDLE, MAC, DONE. busy = (state != IDLE).
- Coefficient write: coef[coef_addr]←coef_data on any edge with coef_we=1, including mid-MAC. The new value takes effect from the next edge, so an in-flight result may mix old and new values.
- Reset values:
  - data_out=0, out_valid=0, busy=0, overrun=0.
  - buffer all 0, wr_ptr=0, phase=0, acc=0, state=IDLE.
  - coef[0]=2^COEF_FRAC (1.0), all other coefs 0.

## Timing
- E0 = clk edge at which the capture is registered.
- MAC runs on edges E1..E_N_TAPS. data_out and out_valid are registered at E(N_TAPS+1), so latency is N_TAPS+1 cycles from capture.
- out_valid is high for exactly one cycle and drops at E(N_TAPS+2).
- busy is high from after E0 until E(N_TAPS+1), i.e. N_TAPS+1 cycles.
- Minimum spacing between computed captures: N_TAPS+2 cycles. Non-computed captures (phase < DECIMATION_RATIO-1) are also dropped if they arrive while busy.
- The cycle after DONE is IDLE, so a capture there is accepted.
- Reset assertion mid-MAC/DONE clears all state immediately (asynchronous). No out_valid occurs for the aborted computation.

## Test plan
- Identity after reset, defaults: captures 100, 200, 300, 400 → out_valid twice, data_out 200 then 400, each N_TAPS+1 cycles after its capture.
- Impulse response: load coef[0..2]=8192 (0.5), others 0. Input 0, 1000, then zeros → outputs 500, 500, then 0; buffer wrap is exercised over more than N_TAPS samples.
- Saturation: coef[0]=32767. Input 2047 → 2047; input -2048 → -2048. Then coef[0]=16384 with input -2048 → -2048 (no clamp).
- Rounding: coef[0]=8192. Input 3 → 2; input -3 → -1; input 1 → 1; input -1 → 0.
- Overrun: data_clk rising every 10 cycles with N_TAPS=16 → overrun set on the first strobe inside a busy window and stays set. Dropped samples do not enter the buffer, which is checked against a reference model.
- Reset: assert rst_n mid-MAC → all outputs 0 immediately and no out_valid after release. With data_clk held high across release, no capture occurs until the next 0→1 transition.
